seg7_bcd_scan: RTL and testbench

- Consumer end of the divider's tick interface.
- Takes the single-cycle tick pulse from the clock divider and advances a 4-digit BCD up/down counter, one step per tick.
- Time-multiplexes the four digits onto one common 7-segment bus with an internal refresh prescaler.
- Sits between the divider and the board's anode/segment pins.

---
 rtl/seg7_bcd_scan.sv | 113 +++++++++++
 tb/tb_seg7_bcd_scan.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_scan.sv
// Four-digit BCD up/down counter advanced by divider ticks, scanned onto one
// shared 7-segment bus with a registered anode/segment output stage.
module seg7_bcd_scan #(
  parameter int REFRESH_DIV    = 12000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        up_dn,
  input  logic        clear,
  input  logic        hold,
  output logic [15:0] count_bcd,
  output logic        wrap,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int             RW          = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0]  REFRESH_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [6:0]     SEG_MASK    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]     AN_MASK     = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    cur_digit;
  logic [15:0]   step_cnt;
  logic          step_carry;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  // Ripple carry/borrow through the digits; a carry out of the top digit is the wrap.
  always_comb begin
    step_cnt   = count_bcd;
    step_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (step_carry) begin
        if (up_dn) begin
          if (count_bcd[4*i +: 4] >= 4'd9) begin
            step_cnt[4*i +: 4] = 4'd0;
          end else begin
            step_cnt[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
            step_carry         = 1'b0;
          end
        end else begin
          if (count_bcd[4*i +: 4] == 4'd0) begin
            step_cnt[4*i +: 4] = 4'd9;
          end else begin
            step_cnt[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
            step_carry         = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    case (digit_idx)
      2'd0:    cur_digit = count_bcd[3:0];
      2'd1:    cur_digit = count_bcd[7:4];
      2'd2:    cur_digit = count_bcd[11:8];
      default: cur_digit = count_bcd[15:12];
    endcase
  end

  // tick_in is a bare enable: every sampled-high cycle is one step, no handshake back.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      count_bcd   <= 16'h0000;
      wrap        <= 1'b0;
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      an          <= 4'b0001 ^ AN_MASK;
      seg         <= glyph(4'd0) ^ SEG_MASK;
    end else begin
      an  <= (4'b0001 << digit_idx) ^ AN_MASK;
      seg <= glyph(cur_digit) ^ SEG_MASK;

      if (refresh_cnt == REFRESH_MAX) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end

      if (clear) begin
        count_bcd <= 16'h0000;
        wrap      <= 1'b0;
      end else if (tick_in && !hold) begin
        count_bcd <= step_cnt;
        wrap      <= step_carry;
      end else begin
        wrap      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_bcd_scan.sv
// Bench for seg7_bcd_scan: integer-valued reference of the count and a
// cycle-count model of the scan, compared against the DUT every cycle.
module tb_seg7_bcd_scan;

  localparam int R = 4;

  logic        clk_in  = 1'b0;
  logic        rst     = 1'b0;
  logic        tick_in = 1'b0;
  logic        up_dn   = 1'b1;
  logic        clear   = 1'b0;
  logic        hold    = 1'b0;
  logic [15:0] count_bcd;
  logic        wrap;
  logic [3:0]  an;
  logic [6:0]  seg;

  seg7_bcd_scan #(.REFRESH_DIV(R), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .up_dn(up_dn), .clear(clear),
    .hold(hold), .count_bcd(count_bcd), .wrap(wrap), .an(an), .seg(seg)
  );

  // clock
  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state: count as a plain integer, edges since reset, expected output regs
  int         m_val = 0;
  int         m_k   = 0;
  logic       m_wrap = 1'b0;
  logic [3:0] m_an   = 4'b1110;
  logic [6:0] m_seg  = 7'h40;

  logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int         p10 [4] = '{1, 10, 100, 1000};

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int idx;
    int d;
    if (!rst) begin
      m_val  = 0;
      m_wrap = 1'b0;
      m_k    = 0;
      m_an   = 4'b1110;
      m_seg  = ~glyph_tab[0];
    end else begin
      idx   = (m_k / R) % 4;
      d     = (m_val / p10[idx]) % 10;
      m_an  = 4'b1111;
      m_an[idx] = 1'b0;
      m_seg = ~glyph_tab[d];
      if (clear) begin
        m_val  = 0;
        m_wrap = 1'b0;
      end else if (tick_in && !hold) begin
        if (up_dn) begin
          m_wrap = (m_val == 9999);
          m_val  = (m_val + 1) % 10000;
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + 9999) % 10000;
        end
      end else begin
        m_wrap = 1'b0;
      end
      m_k++;
    end
  endtask

  // driver: apply inputs for one cycle, advance the model, compare at the falling edge
  task automatic cycle(input logic t, input logic u, input logic c, input logic h, input logic r);
    logic ok;
    tick_in = t;
    up_dn   = u;
    clear   = c;
    hold    = h;
    rst     = r;
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check_eq("count", 32'(count_bcd), 32'(to_bcd(m_val)));
    check_eq("wrap", 32'(wrap), 32'(m_wrap));
    check_eq("an", 32'(an), 32'(m_an));
    check_eq("seg", 32'(seg), 32'(m_seg));
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (count_bcd[4*i +: 4] > 4'd9) ok = 1'b0;
    check_eq("digit_range", 32'(ok), 32'd1);
  endtask

  task automatic up_ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, 1);
  endtask

  initial begin
    repeat (3) cycle(0, 1, 0, 0, 0);
    check_eq("rst_count", 32'(count_bcd), 32'h0000);
    check_eq("rst_wrap", 32'(wrap), 32'd0);
    check_eq("rst_an", 32'(an), 32'hE);
    check_eq("rst_seg", 32'(seg), 32'h40);

    repeat (4) cycle(0, 1, 0, 0, 1);
    check_eq("pre_advance_an", 32'(an), 32'hE);
    cycle(0, 1, 0, 0, 1);
    check_eq("first_advance_an", 32'(an), 32'hD);

    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 0, 0, 1);
      cycle(0, 1, 0, 0, 1);
    end
    check_eq("ten_ticks", 32'(count_bcd), 32'h0010);

    cycle(0, 1, 1, 0, 1);
    up_ticks(9999);
    check_eq("preload", 32'(count_bcd), 32'h9999);
    cycle(1, 1, 0, 0, 1);
    check_eq("up_wrap_cnt", 32'(count_bcd), 32'h0000);
    check_eq("up_wrap_pulse", 32'(wrap), 32'd1);
    cycle(0, 1, 0, 0, 1);
    check_eq("up_wrap_end", 32'(wrap), 32'd0);
    cycle(1, 0, 0, 0, 1);
    check_eq("dn_wrap_cnt", 32'(count_bcd), 32'h9999);
    check_eq("dn_wrap_pulse", 32'(wrap), 32'd1);
    cycle(0, 0, 0, 0, 1);
    check_eq("dn_wrap_end", 32'(wrap), 32'd0);

    cycle(0, 1, 1, 0, 1);
    up_ticks(123);
    cycle(1, 1, 1, 0, 1);
    check_eq("clear_beats_tick", 32'(count_bcd), 32'h0000);
    check_eq("clear_wrap", 32'(wrap), 32'd0);

    up_ticks(42);
    repeat (5) cycle(1, 1, 0, 1, 1);
    check_eq("hold", 32'(count_bcd), 32'h0042);

    cycle(0, 1, 1, 0, 1);
    up_ticks(1234);
    repeat (20) cycle(0, 1, 0, 0, 1);
    check_eq("scan_count", 32'(count_bcd), 32'h1234);

    cycle(0, 1, 1, 0, 1);
    up_ticks(98);
    cycle(1, 1, 0, 0, 1);
    check_eq("b2b_0099", 32'(count_bcd), 32'h0099);
    cycle(1, 1, 0, 0, 1);
    check_eq("b2b_0100", 32'(count_bcd), 32'h0100);
    cycle(1, 1, 0, 0, 1);
    check_eq("b2b_0101", 32'(count_bcd), 32'h0101);
    cycle(1, 1, 0, 0, 0);
    check_eq("mid_rst_count", 32'(count_bcd), 32'h0000);
    check_eq("mid_rst_an", 32'(an), 32'hE);

    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 299) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
